// File: rtl/switch_inv_if.sv
// Stream and status bundle for the switch_inv preimage engine.
// The err member exists only when SWITCH_INV_ERR_EN is defined.
interface switch_inv_if;
    logic        start;
    logic [2:0]  target;
    logic        match_ready;
    logic        busy;
    logic        match_valid;
    logic [3:0]  match_idx;
    logic [15:0] mask;
    logic [4:0]  count;
    logic        done;
`ifdef SWITCH_INV_ERR_EN
    logic        err;
`endif

    modport master (
        output start, target, match_ready,
        input  busy, match_valid, match_idx, mask, count, done
`ifdef SWITCH_INV_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  start, target, match_ready,
        output busy, match_valid, match_idx, mask, count, done
`ifdef SWITCH_INV_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/switch_inv.sv
// switch_inv: preimage engine for the 4->3 switch map F, scanning i = 0..15 for F(i) == target.
// Optional macro SWITCH_INV_ERR_EN adds a sticky err flag for start requests seen while busy.
module switch_inv #(
    parameter int EMIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    switch_inv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [2:0]  tgt_q, tgt_d;
    logic [15:0] mask_q, mask_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        hit;

    // Forward map evaluated at 32 bits, then truncated to the 3-bit code.
    function automatic logic [2:0] f_map(input logic [3:0] i);
        int unsigned x;
        int unsigned r;
        x = 32'(i);
        if (x <= 32'd3)
            r = (2 * x + 32'd7) % 32'd6;
        else if (x <= 32'd10)
            r = (3 * x + 32'd2) % 32'd8;
        else
            r = x / 32'd3;
        return 3'(r);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            tgt_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            tgt_q   <= tgt_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        tgt_d   = tgt_q;
        mask_d  = mask_q;
        count_d = count_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        hit     = (f_map(cand_q) == tgt_q);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tgt_d   = bus.target;
                    cand_d  = '0;
                    mask_d  = '0;
                    count_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    mask_d[cand_q] = 1'b1;
                    count_d        = count_q + 5'd1;
                end
                // Without the stream a match is recorded and the scan simply moves on.
                if (hit && (EMIT_EN != 0)) begin
                    idx_d   = cand_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (cand_q == 4'd15) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cand_d = cand_q + 4'd1;
                end
            end
            HOLD: begin
                if (valid_q && bus.match_ready) begin
                    valid_d = 1'b0;
                    if (cand_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cand_d  = cand_q + 4'd1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.match_valid = valid_q;
    assign bus.match_idx   = idx_q;
    assign bus.mask        = mask_q;
    assign bus.count       = count_q;
    assign bus.done        = done_q;

`ifdef SWITCH_INV_ERR_EN
    logic err_q, err_d;

    // Sticky until the next accepted start; a rejected start changes nothing else.
    always_comb begin
        err_d = err_q;
        if (bus.start) begin
            if (state_q == IDLE)
                err_d = 1'b0;
            else
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.err = err_q;
`endif

endmodule
